// File: rtl/ann_window_sequencer_if.sv
// Host-side bus of the ANN window sequencer: weight/temperature RAM ports,
// ANN core handshake and run status.
interface ann_window_sequencer_if #(
  parameter int DATA_W = 156
);
  logic              start;
  logic              w_rd_en;
  logic [13:0]       w_addr;
  logic [DATA_W-1:0] w_rdata;
  logic              t_rd_en;
  logic [8:0]        t_addr;
  logic [DATA_W-1:0] t_rdata;
  logic              t_wr_en;
  logic [DATA_W-1:0] t_wdata;
  logic [DATA_W-1:0] Weight_in;
  logic              Weight_Save_enable;
  logic [DATA_W-1:0] Temperature_in_0;
  logic [DATA_W-1:0] Temperature_in_1;
  logic [DATA_W-1:0] Temperature_in_2;
  logic [DATA_W-1:0] Temperature_in_3;
  logic              tb_rev_ready_h;
  logic [DATA_W-1:0] Data_out;
  logic              Ready_Signal;
  logic              pred_valid;
  logic [16:0]       pred_data;
  logic [8:0]        pred_day;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, w_rdata, t_rdata, Data_out, Ready_Signal,
    output w_rd_en, w_addr, t_rd_en, t_addr, t_wr_en, t_wdata,
           Weight_in, Weight_Save_enable,
           Temperature_in_0, Temperature_in_1, Temperature_in_2, Temperature_in_3,
           tb_rev_ready_h, pred_valid, pred_data, pred_day, busy, done, err
  );

  modport slave (
    output start, w_rdata, t_rdata, Data_out, Ready_Signal,
    input  w_rd_en, w_addr, t_rd_en, t_addr, t_wr_en, t_wdata,
           Weight_in, Weight_Save_enable,
           Temperature_in_0, Temperature_in_1, Temperature_in_2, Temperature_in_3,
           tb_rev_ready_h, pred_valid, pred_data, pred_day, busy, done, err
  );
endinterface

// File: rtl/ann_window_sequencer.sv
// Drives the ANN predictor one forecast day at a time: streams the day's
// weights, presents the 4-day Tmax window, requests a prediction, scales the
// result by 1/1000 and back-fills the day after the window when it is empty.
module ann_window_sequencer #(
  parameter int DATA_W    = 156,
  parameter int N_WEIGHTS = 40,
  parameter int ONE_YEAR  = 369,
  parameter int REQ_CYC   = 5,
  parameter int GAP_CYC   = 10,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  Clk,
  input  logic                  Reset_h,
  ann_window_sequencer_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start
  // WLOAD | reading N_WEIGHTS weights, streaming them to the ANN one cycle later
  // WGAP  | quiet gap before the window request
  // TREAD | reading mem[d..d+3] into the window, mem[d+4] into the empty check
  // REQ   | ready request held high, early result captured
  // WAIT  | waiting for Ready_Signal, bounded by TIMEOUT
  // DIV   | 26-cycle restoring divide by 1000
  // WB    | prediction pulse, optional back-fill of day d+4
  // NEXT  | advance day or finish
  // DONE  | run finished, returns to IDLE
  typedef enum logic [3:0] {
    S_IDLE, S_WLOAD, S_WGAP, S_TREAD, S_REQ, S_WAIT, S_DIV, S_WB, S_NEXT, S_DONE
  } state_t;

  // One shared down-counter times every state; 11 bits cover TIMEOUT up to 2048.
  localparam int         TMR_W    = 11;
  localparam logic [8:0] LAST_DAY = 9'(ONE_YEAR - 5);

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr, tmr_load;
  logic              tmr_tc;
  logic [8:0]        day;
  logic [25:0]       quo;
  logic [9:0]        rem, rem_nxt;
  logic [10:0]       trial;
  logic              div_ge;
  logic              got;
  logic              ready_hit;
  logic              next_zero;
  logic              wse_q;
  logic              done_q, err_q;
  logic [DATA_W-1:0] temp_q [4];
  logic              unused_data_hi;

  assign tmr_tc    = (tmr == '0);
  assign ready_hit = bus.Ready_Signal && !got;

  // Divider works on the high quotient bit shifted into the partial remainder.
  assign trial   = {rem, quo[25]};
  assign div_ge  = (trial >= 11'd1000);
  assign rem_nxt = div_ge ? 10'(trial - 11'd1000) : trial[9:0];

  // Only the low 26 bits of the ANN result carry the prediction.
  assign unused_data_hi = ^bus.Data_out[DATA_W-1:26];

  // State register.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and strobe/address outputs.
  always_comb begin
    state_nxt          = state;
    bus.w_rd_en        = 1'b0;
    bus.w_addr         = '0;
    bus.t_rd_en        = 1'b0;
    bus.t_addr         = '0;
    bus.t_wr_en        = 1'b0;
    bus.t_wdata        = '0;
    bus.tb_rev_ready_h = 1'b0;
    bus.pred_valid     = 1'b0;
    bus.pred_data      = '0;
    bus.busy           = (state != S_IDLE) && (state != S_DONE);
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_WLOAD;
      S_WLOAD: begin
        bus.w_rd_en = 1'b1;
        bus.w_addr  = 14'(day) * 14'(N_WEIGHTS) + 14'(TMR_W'(N_WEIGHTS - 1) - tmr);
        if (tmr_tc) state_nxt = S_WGAP;
      end
      S_WGAP:  if (tmr_tc) state_nxt = S_TREAD;
      S_TREAD: begin
        if (!tmr_tc) begin
          bus.t_rd_en = 1'b1;
          bus.t_addr  = day + 9'(TMR_W'(5) - tmr);
        end
        if (tmr_tc) state_nxt = S_REQ;
      end
      S_REQ: begin
        bus.tb_rev_ready_h = 1'b1;
        if (tmr_tc) state_nxt = (got || bus.Ready_Signal) ? S_DIV : S_WAIT;
      end
      S_WAIT: begin
        if (bus.Ready_Signal) state_nxt = S_DIV;
        else if (tmr_tc)      state_nxt = S_IDLE;
      end
      S_DIV:   if (tmr_tc) state_nxt = S_WB;
      S_WB: begin
        bus.pred_valid = 1'b1;
        bus.pred_data  = quo[16:0];
        if (next_zero) begin
          bus.t_wr_en = 1'b1;
          bus.t_addr  = day + 9'd4;
          bus.t_wdata = DATA_W'(quo[16:0]);
        end
        state_nxt = S_NEXT;
      end
      S_NEXT:  state_nxt = (day == LAST_DAY) ? S_DONE : S_WLOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Timer reload value for the state being entered.
  always_comb begin
    tmr_load = '0;
    case (state_nxt)
      S_WLOAD: tmr_load = TMR_W'(N_WEIGHTS - 1);
      S_WGAP:  tmr_load = TMR_W'(GAP_CYC - 1);
      S_TREAD: tmr_load = TMR_W'(5);
      S_REQ:   tmr_load = TMR_W'(REQ_CYC - 1);
      S_WAIT:  tmr_load = TMR_W'(TIMEOUT - 1);
      S_DIV:   tmr_load = TMR_W'(25);
      default: tmr_load = '0;
    endcase
  end

  // Timer, day index, window capture, result capture, divider and sticky flags.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      tmr       <= '0;
      day       <= '0;
      quo       <= '0;
      rem       <= '0;
      got       <= 1'b0;
      next_zero <= 1'b0;
      wse_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) temp_q[i] <= '0;
    end else begin
      wse_q <= (state == S_WLOAD);
      if (state_nxt != state) tmr <= tmr_load;
      else if (!tmr_tc)       tmr <= tmr - TMR_W'(1);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            day    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        S_TREAD: begin
          got <= 1'b0;
          if (tmr == TMR_W'(4)) temp_q[0] <= bus.t_rdata;
          if (tmr == TMR_W'(3)) temp_q[1] <= bus.t_rdata;
          if (tmr == TMR_W'(2)) temp_q[2] <= bus.t_rdata;
          if (tmr == TMR_W'(1)) temp_q[3] <= bus.t_rdata;
          if (tmr_tc)           next_zero <= (bus.t_rdata == '0);
        end
        S_REQ, S_WAIT: begin
          if (ready_hit) begin
            quo <= bus.Data_out[25:0];
            rem <= '0;
            got <= 1'b1;
          end
          if (state == S_WAIT && tmr_tc && !bus.Ready_Signal) err_q <= 1'b1;
        end
        S_DIV: begin
          quo <= {quo[24:0], div_ge};
          rem <= rem_nxt;
        end
        S_NEXT: begin
          if (day == LAST_DAY) done_q <= 1'b1;
          else                 day    <= day + 9'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Weight_Save_enable = wse_q;
  assign bus.Weight_in          = wse_q ? bus.w_rdata : '0;
  assign bus.Temperature_in_0   = temp_q[0];
  assign bus.Temperature_in_1   = temp_q[1];
  assign bus.Temperature_in_2   = temp_q[2];
  assign bus.Temperature_in_3   = temp_q[3];
  assign bus.pred_day           = day;
  assign bus.done               = done_q;
  assign bus.err                = err_q;
endmodule

// File: tb/tb_ann_window_sequencer.sv
// Directed bench for ann_window_sequencer with RAM and ANN behavioural models.
module tb_ann_window_sequencer;
  localparam int DATA_W    = 156;
  localparam int N_WEIGHTS = 40;
  localparam int ONE_YEAR  = 8;
  localparam int REQ_CYC   = 5;
  localparam int GAP_CYC   = 10;
  localparam int TIMEOUT   = 1024;

  logic Clk     = 1'b0;
  logic Reset_h = 1'b1;

  ann_window_sequencer_if #(.DATA_W(DATA_W)) bus ();

  ann_window_sequencer #(
    .DATA_W(DATA_W), .N_WEIGHTS(N_WEIGHTS), .ONE_YEAR(ONE_YEAR),
    .REQ_CYC(REQ_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk),
    .Reset_h(Reset_h),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // RAM models: weight word = its address, temperature memory reloaded in reset.
  logic [DATA_W-1:0] mem_init [ONE_YEAR];
  logic [DATA_W-1:0] mem      [ONE_YEAR];

  always @(posedge Clk) begin
    if (Reset_h) begin
      for (int i = 0; i < ONE_YEAR; i++) mem[i] <= mem_init[i];
      bus.w_rdata <= '0;
      bus.t_rdata <= '0;
    end else begin
      if (bus.w_rd_en) bus.w_rdata <= DATA_W'(bus.w_addr);
      if (bus.t_rd_en) bus.t_rdata <= mem[bus.t_addr[2:0]];
      if (bus.t_wr_en) mem[bus.t_addr[2:0]] <= bus.t_wdata;
    end
  end

  // ANN model: one Ready pulse a per-day number of cycles after the request rises.
  logic        ann_on;
  int          ann_delay_tab [4];
  logic [25:0] ann_val_tab   [4];
  int          ann_cnt;
  logic        ann_active, ann_fired;

  always @(posedge Clk) begin
    if (Reset_h) begin
      ann_active       <= 1'b0;
      ann_fired        <= 1'b0;
      ann_cnt          <= 0;
      bus.Ready_Signal <= 1'b0;
      bus.Data_out     <= '0;
    end else begin
      bus.Ready_Signal <= 1'b0;
      if (ann_active) begin
        if (ann_on && ann_cnt >= ann_delay_tab[bus.pred_day[1:0]]) begin
          bus.Ready_Signal <= 1'b1;
          bus.Data_out     <= {{(DATA_W-26){1'b1}}, ann_val_tab[bus.pred_day[1:0]]};
          ann_active       <= 1'b0;
          ann_fired        <= 1'b1;
        end else begin
          ann_cnt <= ann_cnt + 1;
        end
      end else if (bus.tb_rev_ready_h && !ann_fired) begin
        ann_active <= 1'b1;
        ann_cnt    <= 1;
      end else if (!bus.tb_rev_ready_h) begin
        ann_fired <= 1'b0;
      end
    end
  end

  // Monitors, cleared while reset is asserted.
  int   w_rd_cycles, w_bad, w_k, w_groups;
  logic wse_prev;
  int   wlen_q [$];
  logic [DATA_W-1:0] tq0 [$], tq1 [$], tq2 [$], tq3 [$];
  logic [16:0] pq_data [$];
  logic [8:0]  pq_day  [$];
  logic [8:0]  wq_addr [$];
  logic [DATA_W-1:0] wq_data [$];

  always @(negedge Clk) begin
    if (Reset_h) begin
      w_rd_cycles = 0; w_bad = 0; w_k = 0; w_groups = 0; wse_prev = 1'b0;
      wlen_q.delete(); tq0.delete(); tq1.delete(); tq2.delete(); tq3.delete();
      pq_data.delete(); pq_day.delete(); wq_addr.delete(); wq_data.delete();
    end else begin
      if (bus.w_rd_en) w_rd_cycles++;
      if (bus.Weight_Save_enable) begin
        if (bus.Weight_in !== DATA_W'(w_groups * N_WEIGHTS + w_k)) w_bad++;
        w_k++;
      end else if (wse_prev) begin
        wlen_q.push_back(w_k);
        w_k = 0;
        w_groups++;
      end
      wse_prev = bus.Weight_Save_enable;
      if (bus.pred_valid) begin
        pq_data.push_back(bus.pred_data);
        pq_day.push_back(bus.pred_day);
        tq0.push_back(bus.Temperature_in_0);
        tq1.push_back(bus.Temperature_in_1);
        tq2.push_back(bus.Temperature_in_2);
        tq3.push_back(bus.Temperature_in_3);
      end
      if (bus.t_wr_en) begin
        wq_addr.push_back(bus.t_addr);
        wq_data.push_back(bus.t_wdata);
      end
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    Reset_h = 1'b1;
    repeat (3) @(negedge Clk);
    Reset_h = 1'b0;
    @(negedge Clk);
  endtask

  int exp_pred  [4] = '{24, 25, 67108, 0};
  int exp_win   [4][4] = '{'{20, 21, 22, 23}, '{21, 22, 23, 24},
                           '{22, 23, 24, 30}, '{23, 24, 30, 67108}};
  int exp_waddr [3] = '{4, 6, 7};
  int exp_wdata [3] = '{24, 67108, 0};
  int n;

  initial begin
    bus.start = 1'b0;
    ann_on    = 1'b1;
    ann_delay_tab = '{1, 8, 3, 4};
    ann_val_tab   = '{26'd24_999, 26'd25_400, 26'h3FF_FFFF, 26'd999};
    for (int i = 0; i < ONE_YEAR; i++) mem_init[i] = '0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_w_rd_en", bus.w_rd_en, 0);
    chk("rst_ready_h", bus.tb_rev_ready_h, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_pred_valid", bus.pred_valid, 0);
    Reset_h = 1'b0;
    @(negedge Clk);

    // Reset in the middle of the weight stream
    pulse_start();
    chk("busy_after_start", bus.busy, 1);
    chk("w_addr_k0", bus.w_addr, 0);
    repeat (10) @(negedge Clk);
    chk("w_addr_k10", bus.w_addr, 10);
    chk("weight_in_k9", bus.Weight_in, 9);
    chk("wse_mid", bus.Weight_Save_enable, 1);
    #2 Reset_h = 1'b1;
    #1;
    chk("async_w_rd_en", bus.w_rd_en, 0);
    chk("async_wse", bus.Weight_Save_enable, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_w_addr", bus.w_addr, 0);
    chk("async_weight_in", bus.Weight_in, 0);
    repeat (3) @(negedge Clk);
    Reset_h = 1'b0;
    repeat (60) @(negedge Clk);
    chk("post_rst_w_rd", w_rd_cycles, 0);
    chk("post_rst_wse_groups", wlen_q.size(), 0);
    chk("post_rst_busy", bus.busy, 0);

    // ANN never answers
    ann_on = 1'b0;
    do_reset();
    pulse_start();
    n = 0;
    while (!bus.tb_rev_ready_h && n < 500) begin @(negedge Clk); n++; end
    chk("to_req_seen", bus.tb_rev_ready_h, 1);
    n = 0;
    while (!bus.err && n < 3000) begin @(negedge Clk); n++; end
    chk("to_cycles", n, REQ_CYC + TIMEOUT);
    chk("to_err", bus.err, 1);
    chk("to_busy", bus.busy, 0);
    chk("to_ready_h", bus.tb_rev_ready_h, 0);
    chk("to_no_pred", pq_data.size(), 0);
    chk("to_day_kept", bus.pred_day, 0);
    ann_on = 1'b1;
    pulse_start();
    chk("start_clears_err", bus.err, 0);
    chk("restart_busy", bus.busy, 1);

    // Full run over 4 days with back-fill
    for (int i = 0; i < ONE_YEAR; i++) mem_init[i] = '0;
    mem_init[0] = 20; mem_init[1] = 21; mem_init[2] = 22; mem_init[3] = 23;
    mem_init[5] = 30;
    do_reset();
    pulse_start();
    n = 0;
    while (pq_day.size() == 0 && n < 1000) begin @(negedge Clk); n++; end
    chk("first_pred_seen", pq_day.size(), 1);
    pulse_start();
    chk("start_while_busy_busy", bus.busy, 1);
    n = 0;
    while (!bus.done && n < 3000) begin @(negedge Clk); n++; end
    chk("run_done", bus.done, 1);
    repeat (2) @(negedge Clk);
    chk("run_done_sticky", bus.done, 1);
    chk("run_busy_end", bus.busy, 0);
    chk("run_pred_count", pq_data.size(), 4);
    for (int i = 0; i < 4 && i < pq_data.size(); i++) begin
      chk($sformatf("pred_day_%0d", i), pq_day[i], i);
      chk($sformatf("pred_data_%0d", i), pq_data[i], exp_pred[i]);
      chk($sformatf("win0_day%0d", i), tq0[i], exp_win[i][0]);
      chk($sformatf("win1_day%0d", i), tq1[i], exp_win[i][1]);
      chk($sformatf("win2_day%0d", i), tq2[i], exp_win[i][2]);
      chk($sformatf("win3_day%0d", i), tq3[i], exp_win[i][3]);
    end
    chk("wb_count", wq_addr.size(), 3);
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      chk($sformatf("wb_addr_%0d", i), wq_addr[i], exp_waddr[i]);
      chk($sformatf("wb_data_%0d", i), wq_data[i], exp_wdata[i]);
    end
    chk("w_groups", wlen_q.size(), 4);
    for (int i = 0; i < 4 && i < wlen_q.size(); i++)
      chk($sformatf("w_len_%0d", i), wlen_q[i], N_WEIGHTS);
    chk("w_values", w_bad, 0);
    chk("w_rd_cycles", w_rd_cycles, 4 * N_WEIGHTS);
    #2 Reset_h = 1'b1;
    #1;
    chk("rst_clears_done", bus.done, 0);
    repeat (2) @(negedge Clk);
    Reset_h = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
